mem_op_sequencer: RTL

Sequences multi-step write and erase operations on the SPI flash through the existing memory controller handshake (MEMCMD/MEMADDR/MEMVAL/MEMTRIG, MEM_busy/MEMDATA). One request expands into this sequence:
- WREN;
- the program/erase command;
- repeated RDSR1 polls until the WIP bit clears, or a timeout.

It sits between the SPI command decoder and the memory controller. It frees the decoder from hand-issuing WREN and spinning on status reads.

---
 rtl/mem_op_sequencer.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_op_sequencer.sv
// Expands one erase/program request into WREN, the op command and RDSR1 polling on the
// memory-controller trigger/busy handshake. Define MEM_SEQ_WEL_CHECK_EN to verify WEL before the op.
module mem_op_sequencer #(
    parameter int POLL_GAP = 64,
    parameter int POLL_MAX = 16'hFFFF,
    parameter int ACK_MAX  = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        OP_REQ,
    input  logic [1:0]  OP_CODE,
    input  logic [23:0] OP_ADDR,
    input  logic [23:0] OP_DATA,
    output logic        OP_BUSY,
    output logic        OP_DONE,
    output logic        OP_ERR,
    output logic [1:0]  OP_ERRCODE,
    output logic [7:0]  OP_STATUS,
    output logic [7:0]  MEMCMD,
    output logic [23:0] MEMADDR,
    output logic [23:0] MEMVAL,
    output logic        MEMTRIG,
    output logic        MEMQUAD,
    input  logic [47:0] MEMDATA,
    input  logic        MEM_busy
);
    localparam int CNT_MAX = (ACK_MAX > POLL_GAP) ? ACK_MAX : POLL_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int POLL_W  = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WREN_ISSUE,
        S_WREN_WAIT,
`ifdef MEM_SEQ_WEL_CHECK_EN
        S_WEL_ISSUE,
        S_WEL_WAIT,
`endif
        S_OP_ISSUE,
        S_OP_WAIT,
        S_GAP,
        S_POLL_ISSUE,
        S_POLL_WAIT,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          errcode_q, errcode_d;
    logic [7:0]          status_q, status_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [23:0]         addr_q, addr_d;
    logic [23:0]         val_q, val_d;
    logic                trig_q, trig_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [POLL_W-1:0]   poll_q, poll_d;
    logic [1:0]          code_q, code_d;
    logic [23:0]         oaddr_q, oaddr_d;
    logic [23:0]         odata_q, odata_d;

    logic                in_wait;
    logic                txn_done;
    logic [7:0]          op_cmd;
    logic [23:0]         op_addr;
    logic [23:0]         op_val;
    logic                unused_memdata;

    assign unused_memdata = ^MEMDATA[47:8];

`ifdef MEM_SEQ_WEL_CHECK_EN
    assign in_wait = (state_q == S_WREN_WAIT) || (state_q == S_WEL_WAIT) ||
                     (state_q == S_OP_WAIT) || (state_q == S_POLL_WAIT);
`else
    assign in_wait = (state_q == S_WREN_WAIT) || (state_q == S_OP_WAIT) ||
                     (state_q == S_POLL_WAIT);
`endif
    assign txn_done = !trig_q && !MEM_busy;

    always_comb begin
        op_cmd  = 8'h02;
        op_addr = oaddr_q;
        op_val  = odata_q;
        unique case (code_q)
            2'b00:   begin op_cmd = 8'hC7; op_addr = '0; op_val = '0; end
            2'b01:   begin op_cmd = 8'hD8; op_val = '0; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        err_d     = 1'b0;
        errcode_d = errcode_q;
        status_d  = status_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        val_d     = val_q;
        trig_d    = trig_q;
        cnt_d     = cnt_q;
        poll_d    = poll_q;
        code_d    = code_q;
        oaddr_d   = oaddr_q;
        odata_d   = odata_q;

        // Shared trigger/ack phase of every *_WAIT; completion is handled per state below.
        if (in_wait && trig_q) begin
            if (MEM_busy) begin
                trig_d = 1'b0;
            end else if (cnt_q == CNT_W'(ACK_MAX - 1)) begin
                trig_d    = 1'b0;
                errcode_d = 2'b01;
                state_d   = S_FINISH;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                busy_d = OP_REQ;
                cmd_d  = '0;
                addr_d = '0;
                val_d  = '0;
                if (OP_REQ) begin
                    code_d    = OP_CODE;
                    oaddr_d   = OP_ADDR;
                    odata_d   = OP_DATA;
                    errcode_d = '0;
                    poll_d    = '0;
                    if (OP_CODE == 2'b11) begin
                        errcode_d = 2'b11;
                        state_d   = S_FINISH;
                    end else begin
                        state_d = S_WREN_ISSUE;
                    end
                end
            end
            S_WREN_ISSUE: begin
                cmd_d   = 8'h06;
                addr_d  = '0;
                val_d   = '0;
                trig_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_WREN_WAIT;
            end
            S_WREN_WAIT: begin
                if (txn_done) begin
`ifdef MEM_SEQ_WEL_CHECK_EN
                    state_d = S_WEL_ISSUE;
`else
                    state_d = S_OP_ISSUE;
`endif
                end
            end
`ifdef MEM_SEQ_WEL_CHECK_EN
            S_WEL_ISSUE: begin
                cmd_d   = 8'h05;
                addr_d  = '0;
                val_d   = '0;
                trig_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_WEL_WAIT;
            end
            S_WEL_WAIT: begin
                if (txn_done) begin
                    status_d = MEMDATA[7:0];
                    if (!MEMDATA[1]) begin
                        errcode_d = 2'b11;
                        state_d   = S_FINISH;
                    end else begin
                        state_d = S_OP_ISSUE;
                    end
                end
            end
`endif
            S_OP_ISSUE: begin
                cmd_d   = op_cmd;
                addr_d  = op_addr;
                val_d   = op_val;
                trig_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_OP_WAIT;
            end
            S_OP_WAIT: begin
                if (txn_done) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(POLL_GAP - 1)) state_d = S_POLL_ISSUE;
                else                               cnt_d   = cnt_q + 1'b1;
            end
            S_POLL_ISSUE: begin
                cmd_d   = 8'h05;
                addr_d  = '0;
                val_d   = '0;
                trig_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (txn_done) begin
                    status_d = MEMDATA[7:0];
                    poll_d   = poll_q + 1'b1;
                    if (!MEMDATA[0]) begin
                        state_d = S_FINISH;
                    end else if (poll_q == POLL_W'(POLL_MAX - 1)) begin
                        errcode_d = 2'b10;
                        state_d   = S_FINISH;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                err_d   = (errcode_q != 2'b00);
                cmd_d   = '0;
                addr_d  = '0;
                val_d   = '0;
                trig_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            errcode_q <= '0;
            status_q  <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            val_q     <= '0;
            trig_q    <= 1'b0;
            cnt_q     <= '0;
            poll_q    <= '0;
            code_q    <= '0;
            oaddr_q   <= '0;
            odata_q   <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            errcode_q <= errcode_d;
            status_q  <= status_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            val_q     <= val_d;
            trig_q    <= trig_d;
            cnt_q     <= cnt_d;
            poll_q    <= poll_d;
            code_q    <= code_d;
            oaddr_q   <= oaddr_d;
            odata_q   <= odata_d;
        end
    end

    assign OP_BUSY    = busy_q;
    assign OP_DONE    = done_q;
    assign OP_ERR     = err_q;
    assign OP_ERRCODE = errcode_q;
    assign OP_STATUS  = status_q;
    assign MEMCMD     = cmd_q;
    assign MEMADDR    = addr_q;
    assign MEMVAL     = val_q;
    assign MEMTRIG    = trig_q;
    assign MEMQUAD    = 1'b0;

endmodule
